// File: rtl/store_buffer_pkg.sv
// Shared types and helpers for the store buffer: entry layout, lane count
// and the byte-lane merge used when building forwarded load data.
package store_buffer_pkg;

  localparam int SB_LANES   = 4;
  localparam int SB_DATA_W  = 8 * SB_LANES;
  localparam int SB_WADDR_W = 30;

  typedef struct packed {
    logic [SB_WADDR_W-1:0] waddr;
    logic [SB_DATA_W-1:0]  data;
    logic [SB_LANES-1:0]   mask;
  } sb_entry_t;

  // Overlay the lanes selected by sel from upd onto base.
  function automatic logic [SB_DATA_W-1:0] sb_merge_bytes(
    input logic [SB_DATA_W-1:0] base,
    input logic [SB_DATA_W-1:0] upd,
    input logic [SB_LANES-1:0]  sel
  );
    logic [SB_DATA_W-1:0] r;
    r = base;
    for (int b = 0; b < SB_LANES; b++) begin
      if (sel[b]) r[8*b +: 8] = upd[8*b +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/store_buffer_match.sv
// Load-vs-pending-store lookup: per-entry word address compare and an
// oldest-to-youngest byte merge so the youngest store wins each lane.
module store_buffer_match
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  sb_entry_t              entries [DEPTH],
  input  logic [DEPTH-1:0]       valid,
  input  logic [PTR_W-1:0]       head,
  input  logic [SB_WADDR_W-1:0]  ld_waddr,
  input  logic [SB_LANES-1:0]    ld_mask,
  output logic                   hit,
  output logic [SB_LANES-1:0]    mask,
  output logic [SB_DATA_W-1:0]   data
);

  logic [PTR_W-1:0]    idx;
  logic [SB_LANES-1:0] lanes;

  always_comb begin
    hit   = 1'b0;
    mask  = '0;
    data  = '0;
    idx   = '0;
    lanes = '0;
    // Walk from the head (oldest) so later matches overwrite earlier lanes.
    for (int i = 0; i < DEPTH; i++) begin
      idx   = head + PTR_W'(i);
      lanes = entries[idx].mask & ld_mask;
      if (valid[idx] && (entries[idx].waddr == ld_waddr) && (lanes != '0)) begin
        hit  = 1'b1;
        mask = mask | lanes;
        data = sb_merge_bytes(data, entries[idx].data, lanes);
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// Circular FIFO store buffer between the store mask stage and data memory.
// Define STORE_FWD_EN to forward buffered bytes to loads instead of stalling.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              st_valid_i,
  input  logic [ADDR_W-1:0] st_addr_i,
  input  logic [WIDTH-1:0]  st_data_i,
  input  logic [3:0]        st_mask_i,
  output logic              st_ready_o,
  input  logic              ld_valid_i,
  input  logic [ADDR_W-1:0] ld_addr_i,
  input  logic [3:0]        ld_mask_i,
  output logic              ld_stall_o,
  output logic [3:0]        ld_fwd_mask_o,
  output logic [WIDTH-1:0]  ld_fwd_data_o,
  output logic              mem_req_valid_o,
  output logic [ADDR_W-3:0] mem_req_addr_o,
  output logic [WIDTH-1:0]  mem_req_data_o,
  output logic [3:0]        mem_req_mask_o,
  input  logic              mem_req_ready_i,
  output logic              empty_o
);

  localparam int PTR_W = $clog2(DEPTH);

  sb_entry_t             mem_q [DEPTH];
  sb_entry_t             new_entry;
  sb_entry_t             head_entry;
  logic [PTR_W-1:0]      head_q, tail_q;
  logic [PTR_W:0]        count_q;
  logic                  enq, deq;
  logic [DEPTH-1:0]      valid;
  logic [PTR_W-1:0]      rel;
  logic                  m_hit;
  logic [SB_LANES-1:0]   m_mask;
  logic [SB_DATA_W-1:0]  m_data;

  // Both ports transfer on a cycle where valid && ready are high at the
  // rising edge; the memory side holds its payload while valid && !ready.
  assign st_ready_o      = (count_q != (PTR_W+1)'(DEPTH));
  assign empty_o         = (count_q == '0);
  assign mem_req_valid_o = !empty_o;
  assign enq             = st_valid_i && st_ready_o && (st_mask_i != 4'b0000);
  assign deq             = mem_req_valid_o && mem_req_ready_i;

  assign new_entry.waddr = SB_WADDR_W'(st_addr_i[ADDR_W-1:2]);
  assign new_entry.data  = st_data_i;
  assign new_entry.mask  = st_mask_i;

  assign head_entry      = mem_q[head_q];
  assign mem_req_addr_o  = (ADDR_W-2)'(head_entry.waddr);
  assign mem_req_data_o  = head_entry.data;
  assign mem_req_mask_o  = head_entry.mask;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (enq) tail_q <= tail_q + 1'b1;
      if (deq) head_q <= head_q + 1'b1;
      case ({enq, deq})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Payload storage needs no reset: occupancy is tracked by count_q alone.
  always_ff @(posedge clk_i) begin
    if (enq) mem_q[tail_q] <= new_entry;
  end

  always_comb begin
    valid = '0;
    rel   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      rel      = PTR_W'(i) - head_q;
      valid[i] = ({1'b0, rel} < count_q);
    end
  end

  store_buffer_match #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_match (
    .entries  (mem_q),
    .valid    (valid),
    .head     (head_q),
    .ld_waddr (SB_WADDR_W'(ld_addr_i[ADDR_W-1:2])),
    .ld_mask  (ld_mask_i),
    .hit      (m_hit),
    .mask     (m_mask),
    .data     (m_data)
  );

`ifdef STORE_FWD_EN
  logic unused_bits;
  assign unused_bits   = ^{st_addr_i[1:0], ld_addr_i[1:0]};
  assign ld_fwd_mask_o = ld_valid_i ? m_mask : 4'b0000;
  assign ld_fwd_data_o = ld_valid_i ? m_data : '0;
  assign ld_stall_o    = ld_valid_i && m_hit && ((ld_mask_i & ~m_mask) != 4'b0000);
`else
  logic unused_bits;
  assign unused_bits   = ^{st_addr_i[1:0], ld_addr_i[1:0], m_mask, m_data};
  assign ld_fwd_mask_o = 4'b0000;
  assign ld_fwd_data_o = '0;
  assign ld_stall_o    = ld_valid_i && m_hit;
`endif

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: reset, drain handshake, full/wrap,
// zero-mask discard, load stall/forward checks and reset mid-drain.
module tb_store_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        st_valid;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic [3:0]  st_mask;
  logic        st_ready;
  logic        ld_valid;
  logic [31:0] ld_addr;
  logic [3:0]  ld_mask;
  logic        ld_stall;
  logic [3:0]  ld_fwd_mask;
  logic [31:0] ld_fwd_data;
  logic        mem_req_valid;
  logic [29:0] mem_req_addr;
  logic [31:0] mem_req_data;
  logic [3:0]  mem_req_mask;
  logic        mem_req_ready;
  logic        empty;

  int vectors = 0;
  int errs    = 0;

  store_buffer #(.WIDTH(32), .ADDR_W(32), .DEPTH(4)) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .st_valid_i      (st_valid),
    .st_addr_i       (st_addr),
    .st_data_i       (st_data),
    .st_mask_i       (st_mask),
    .st_ready_o      (st_ready),
    .ld_valid_i      (ld_valid),
    .ld_addr_i       (ld_addr),
    .ld_mask_i       (ld_mask),
    .ld_stall_o      (ld_stall),
    .ld_fwd_mask_o   (ld_fwd_mask),
    .ld_fwd_data_o   (ld_fwd_data),
    .mem_req_valid_o (mem_req_valid),
    .mem_req_addr_o  (mem_req_addr),
    .mem_req_data_o  (mem_req_data),
    .mem_req_mask_o  (mem_req_mask),
    .mem_req_ready_i (mem_req_ready),
    .empty_o         (empty)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic look();
    @(negedge clk);
  endtask

  task automatic put_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    st_valid = 1'b1;
    st_addr  = a;
    st_data  = d;
    st_mask  = m;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; st_valid = 1'b0; st_addr = '0; st_data = '0; st_mask = '0;
    ld_valid = 1'b0; ld_addr = '0; ld_mask = '0; mem_req_ready = 1'b0;
    cyc(); cyc();
    rst = 1'b0;

    // Reset state
    look();
    chk("rst_st_ready", st_ready, 1);
    chk("rst_empty", empty, 1);
    chk("rst_mem_valid", mem_req_valid, 0);
    chk("rst_ld_stall", ld_stall, 0);
    chk("rst_fwd_mask", ld_fwd_mask, 0);
    cyc();

    // Single store, memory stalls three cycles then accepts
    put_store(32'h100, 32'h0000_00AB, 4'b0001);
    look();
    chk("empty_same_cycle", empty, 1);
    cyc();
    st_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      look();
      chk("hold_valid", mem_req_valid, 1);
      chk("hold_addr", mem_req_addr, 30'h40);
      chk("hold_data", mem_req_data, 32'h0000_00AB);
      chk("hold_mask", mem_req_mask, 4'b0001);
      cyc();
    end
    mem_req_ready = 1'b1;
    look();
    chk("deq_valid", mem_req_valid, 1);
    chk("deq_addr", mem_req_addr, 30'h40);
    cyc();
    mem_req_ready = 1'b0;
    look();
    chk("after_deq_empty", empty, 1);
    chk("after_deq_valid", mem_req_valid, 0);
    cyc();

    // Fill to DEPTH, fifth store waits for the first dequeue, wrap order
    for (int k = 0; k < 4; k++) begin
      put_store(32'h1000 + 32'(4*k), 32'hD0 + 32'(k), 4'hF);
      look();
      chk("fill_ready", st_ready, 1);
      cyc();
    end
    put_store(32'h1010, 32'hD4, 4'hF);
    mem_req_ready = 1'b1;
    look();
    chk("full_not_ready", st_ready, 0);
    chk("full_head_data", mem_req_data, 32'hD0);
    cyc();
    mem_req_ready = 1'b0;
    look();
    chk("fifth_ready", st_ready, 1);
    chk("fifth_head_data", mem_req_data, 32'hD1);
    cyc();
    st_valid = 1'b0;
    mem_req_ready = 1'b1;
    look();
    chk("refull_not_ready", st_ready, 0);
    for (int k = 1; k <= 4; k++) begin
      chk("wrap_data", mem_req_data, 32'hD0 + 32'(k));
      chk("wrap_addr", mem_req_addr, 30'h400 + 30'(k));
      cyc();
      look();
    end
    chk("wrap_empty", empty, 1);
    mem_req_ready = 1'b0;
    cyc();

    // Zero-mask store is consumed without entering the buffer
    put_store(32'h500, 32'h77, 4'b0000);
    look();
    chk("zmask_ready", st_ready, 1);
    cyc();
    st_valid = 1'b0;
    look();
    chk("zmask_empty", empty, 1);
    chk("zmask_valid", mem_req_valid, 0);
    cyc();

    // Overlapping stores to 0x200, load full word
    put_store(32'h200, 32'h1122_3344, 4'hF);
    ld_valid = 1'b1; ld_addr = 32'h200; ld_mask = 4'hF;
    look();
    chk("ld_not_visible", ld_stall, 0);
    cyc();
    put_store(32'h200, 32'h0000_00AA, 4'b0001);
    cyc();
    st_valid = 1'b0;
    look();
`ifdef STORE_FWD_EN
    chk("fwd_data", ld_fwd_data, 32'h1122_33AA);
    chk("fwd_mask", ld_fwd_mask, 4'hF);
    chk("fwd_stall", ld_stall, 0);
`else
    chk("nofwd_stall", ld_stall, 1);
    chk("nofwd_mask", ld_fwd_mask, 0);
    chk("nofwd_data", ld_fwd_data, 0);
`endif
    cyc();
    mem_req_ready = 1'b1;
    look();
`ifdef STORE_FWD_EN
    chk("deq_head_fwd_data", ld_fwd_data, 32'h1122_33AA);
`else
    chk("deq_head_stall", ld_stall, 1);
`endif
    cyc();
    look();
`ifdef STORE_FWD_EN
    chk("partial_fwd_mask", ld_fwd_mask, 4'b0001);
    chk("partial_fwd_data", ld_fwd_data, 32'h0000_00AA);
`endif
    chk("partial_stall", ld_stall, 1);
    cyc();
    look();
    chk("drained_stall", ld_stall, 0);
    chk("drained_empty", empty, 1);
    cyc();
    mem_req_ready = 1'b0;

    // Disjoint and partial lane overlap at 0x300
    ld_valid = 1'b0;
    put_store(32'h300, 32'h0000_5566, 4'b0011);
    cyc();
    st_valid = 1'b0;
    ld_valid = 1'b1; ld_addr = 32'h300; ld_mask = 4'b1100;
    look();
    chk("disjoint_stall", ld_stall, 0);
    chk("disjoint_mask", ld_fwd_mask, 0);
    cyc();
    ld_mask = 4'hF;
    look();
    chk("overlap_stall", ld_stall, 1);
`ifdef STORE_FWD_EN
    chk("overlap_fwd_mask", ld_fwd_mask, 4'b0011);
    chk("overlap_fwd_data", ld_fwd_data, 32'h0000_5566);
`endif
    cyc();
    ld_valid = 1'b0;
    look();
    chk("ldoff_stall", ld_stall, 0);
    chk("ldoff_mask", ld_fwd_mask, 0);
    chk("ldoff_data", ld_fwd_data, 0);
    cyc();

    // Reset while draining three entries
    put_store(32'h400, 32'hCAFE_0001, 4'hF);
    cyc();
    put_store(32'h404, 32'hCAFE_0002, 4'hF);
    cyc();
    st_valid = 1'b0;
    mem_req_ready = 1'b1;
    look();
    chk("pre_rst_valid", mem_req_valid, 1);
    chk("pre_rst_head", mem_req_addr, 30'hC0);
    rst = 1'b1;
    cyc();
    look();
    chk("rst_mid_empty", empty, 1);
    chk("rst_mid_valid", mem_req_valid, 0);
    chk("rst_mid_ready", st_ready, 1);
    rst = 1'b0;
    mem_req_ready = 1'b0;
    cyc();
    look();
    chk("post_rst_empty", empty, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
